// File: rtl/exp_host_driver_pkg.sv
// Shared definitions for the exponent-engine host driver: state encoding,
// timeout default and counter width.
// Used by the driver, its watchdog counter and the bench.
package exp_host_driver_pkg;

   localparam int TIMEOUT_DEF = 255;
   localparam int CNT_W       = 8;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD_N    = 3'd1,
      S_LOAD_X    = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_RESP      = 3'd5
   } state_e;

   // States in which the watchdog counts cycles
   function automatic logic is_wait(input state_e s);
      return (s == S_WAIT_BUSY) || (s == S_WAIT_DONE);
   endfunction

endpackage

// File: rtl/exp_host_driver_if.sv
// Request/response handshake plus serial engine bus for exp_host_driver.
// Pure wiring, no latency.
// slave = driver side, master = requester/engine side.
interface exp_host_driver_if;

   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_x;
   logic [3:0]  req_n;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_y;
   logic        resp_err;
   logic [3:0]  eng_bus;
   logic        eng_start;
   logic        eng_ready;
   logic [15:0] eng_y;

   modport slave (
      input  req_valid, req_x, req_n, resp_ready, eng_ready, eng_y,
      output req_ready, resp_valid, resp_y, resp_err, eng_bus, eng_start
   );

   modport master (
      output req_valid, req_x, req_n, resp_ready, eng_ready, eng_y,
      input  req_ready, resp_valid, resp_y, resp_err, eng_bus, eng_start
   );

endinterface

// File: rtl/exp_wdog_counter.sv
// Watchdog cycle counter for the engine wait states.
// expired_o is combinational from the count: asserts on the LIMIT-th enabled cycle.
// No backpressure; clear has priority over enable.
module exp_wdog_counter
   import exp_host_driver_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [CNT_W-1:0] cnt_q;

   // Count enabled cycles, restarting from zero on each state entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        cnt_q <= '0;
      else if (clr_i) cnt_q <= '0;
      else if (en_i)  cnt_q <= cnt_q + 1'b1;
   end

   // Count starts at 0 on the first waiting cycle, so LIMIT-1 marks the LIMIT-th cycle
   assign expired_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/exp_host_driver.sv
// Host-side driver: serialises n then x to the exponent engine and returns its result.
// Latency: 2 load cycles + busy-wait + done-wait, response on the following cycle.
// One request in flight; response held until resp_ready, req_ready only in IDLE.
module exp_host_driver
   import exp_host_driver_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   exp_host_driver_if.slave  io
);

   state_e      state_q, state_d;
   logic [3:0]  x_q, x_d;
   logic [3:0]  n_q, n_d;
   logic [15:0] y_q, y_d;
   logic        err_q, err_d;

   logic        wd_clr, wd_en, wd_expired;
   logic        req_ready_w, resp_valid_w, eng_start_w;
   logic [3:0]  eng_bus_w;

   exp_wdog_counter #(.LIMIT(TIMEOUT)) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (wd_clr),
      .en_i      (wd_en),
      .expired_o (wd_expired)
   );

   // Restart the watchdog on every state change, count only while waiting on the engine
   assign wd_clr = (state_d != state_q);
   assign wd_en  = is_wait(state_q);

   // State and operand/result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         n_q     <= '0;
         y_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         n_q     <= n_d;
         y_q     <= y_d;
         err_q   <= err_d;
      end
   end

   // Next-state, register updates and Moore outputs
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      n_d          = n_q;
      y_d          = y_q;
      err_d        = err_q;
      req_ready_w  = 1'b0;
      resp_valid_w = 1'b0;
      eng_start_w  = 1'b0;
      eng_bus_w    = '0;
      case (state_q)
         S_IDLE: begin
            req_ready_w = 1'b1;
            if (io.req_valid) begin
               x_d     = io.req_x;
               n_d     = io.req_n;
               state_d = S_LOAD_N;
            end
         end
         S_LOAD_N: begin
            eng_start_w = 1'b1;
            eng_bus_w   = n_q;
            state_d     = S_LOAD_X;
         end
         S_LOAD_X: begin
            eng_start_w = 1'b1;
            eng_bus_w   = x_q;
            state_d     = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            // An engine edge seen on the same cycle as expiry still counts as in time
            if (!io.eng_ready) begin
               state_d = S_WAIT_DONE;
            end else if (wd_expired) begin
               y_d     = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_WAIT_DONE: begin
            if (io.eng_ready) begin
               y_d     = io.eng_y;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (wd_expired) begin
               y_d     = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            resp_valid_w = 1'b1;
            if (io.resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign io.req_ready  = req_ready_w;
   assign io.resp_valid = resp_valid_w;
   assign io.resp_y     = y_q;
   assign io.resp_err   = err_q;
   assign io.eng_start  = eng_start_w;
   assign io.eng_bus    = eng_bus_w;

endmodule
